// File: rtl/rst_seq.sv
// Remote-domain reset sequencer: asserts a reset request, waits for the remote
// acknowledge to fall then rise, and reports completion. Optional wait-phase
// timeout is enabled by defining RST_SEQ_TIMEOUT_EN.
module rst_seq #(
  parameter int DEPTH      = 2,
  parameter int MIN_ASSERT = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic       src_clk,
  input  logic       src_rst_n,
  input  logic       rst_req,
  output logic       dst_rst_req_n,
  input  logic       ack_rst_n,
  output logic       busy,
  output logic       done,
  output logic       timeout_err,
  output logic [2:0] dbg_state_o
);

  if (DEPTH < 2 || DEPTH > 4) begin : g_bad_depth
    $error("rst_seq: DEPTH must be 2..4");
  end
  if (MIN_ASSERT < 1 || MIN_ASSERT > 65535) begin : g_bad_min_assert
    $error("rst_seq: MIN_ASSERT must be 1..65535");
  end
  if (TIMEOUT < 1 || TIMEOUT > (1 << 20)) begin : g_bad_timeout
    $error("rst_seq: TIMEOUT must be 1..2^20");
  end

  localparam int CW = $clog2(MIN_ASSERT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MIN_ASSERT - 1);

  typedef enum logic [2:0] {
    ASSERT  = 3'd0,
    WAIT_LO = 3'd1,
    RELEASE = 3'd2,
    WAIT_HI = 3'd3,
    IDLE    = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DEPTH-1:0] sync_q;
  logic            ack_s;
  logic            dst_q, busy_q, done_q, done_d;
  logic            err_d;

  // Return-path synchronizer; resets to "remote in reset".
  always_ff @(posedge src_clk) begin
    if (!src_rst_n) sync_q <= '0;
    else            sync_q <= {sync_q[DEPTH-2:0], ack_rst_n};
  end
  assign ack_s = sync_q[DEPTH-1];

`ifdef RST_SEQ_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  logic [WW-1:0] wait_q, wait_d;
  logic          err_q;

  always_ff @(posedge src_clk) begin
    if (!src_rst_n) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end
  assign timeout_err = err_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge src_clk) begin
    if (!src_rst_n) begin
      state_q <= ASSERT;
      cnt_q   <= '0;
      dst_q   <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dst_q   <= (state_d == RELEASE) || (state_d == WAIT_HI) || (state_d == IDLE);
      busy_q  <= (state_d != IDLE);
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
    err_d   = err_q;
    wait_d  = wait_q;
`else
    err_d   = 1'b0;
`endif
    case (state_q)
      ASSERT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = WAIT_LO;
`ifdef RST_SEQ_TIMEOUT_EN
          wait_d  = '0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_LO: begin
        if (!ack_s) begin
          state_d = RELEASE;
        end
`ifdef RST_SEQ_TIMEOUT_EN
        else if (wait_q == WAIT_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
`endif
      end
      RELEASE: begin
        state_d = WAIT_HI;
`ifdef RST_SEQ_TIMEOUT_EN
        wait_d  = '0;
`endif
      end
      WAIT_HI: begin
        if (ack_s) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
`ifdef RST_SEQ_TIMEOUT_EN
        else if (wait_q == WAIT_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
`endif
      end
      IDLE: begin
        // Requests outside IDLE fall through every other arm and are dropped.
        if (rst_req) begin
          state_d = ASSERT;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = ASSERT;
    endcase
  end

  assign dst_rst_req_n = dst_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign dbg_state_o   = state_q;

  logic unused_err;
  assign unused_err = err_d;

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: directed sequences with a looped-back remote reset; a
// monitor scores each done pulse against the expected reset-low duration.
module tb_rst_seq;

  logic       clk = 1'b0;
  logic       src_rst_n;
  logic       rst_req;
  logic       dst_rst_req_n;
  logic       ack_rst_n;
  logic       busy;
  logic       done;
  logic       timeout_err;
  logic [2:0] dbg_state;

  // 0 = loop back through 3-cycle delay, 1 = force high, 2 = force low
  int         ack_mode = 0;
  logic       d1 = 1'b0, d2 = 1'b0, d3 = 1'b0;

  logic [15:0] exp_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  int          low_cnt = 0;
  logic        prev_dst = 1'b0;

  localparam logic [2:0] ST_ASSERT  = 3'd0;
  localparam logic [2:0] ST_RELEASE = 3'd2;
  localparam logic [2:0] ST_IDLE    = 3'd4;
  localparam int         TMO        = 64;

  rst_seq #(.DEPTH(2), .MIN_ASSERT(8), .TIMEOUT(TMO)) dut (
    .src_clk      (clk),
    .src_rst_n    (src_rst_n),
    .rst_req      (rst_req),
    .dst_rst_req_n(dst_rst_req_n),
    .ack_rst_n    (ack_rst_n),
    .busy         (busy),
    .done         (done),
    .timeout_err  (timeout_err),
    .dbg_state_o  (dbg_state)
  );

  // clock / remote loopback
  always #5 clk = ~clk;

  always @(posedge clk) begin
    d1 <= dst_rst_req_n;
    d2 <= d1;
    d3 <= d2;
  end
  assign ack_rst_n = (ack_mode == 0) ? d3 : (ack_mode == 1);

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run time exceeded, summary not reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req();
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("wait_idle_busy", 32'(busy), 32'd0);
  endtask

  // scoreboard monitor: each done must match a queued reset-low length
  always @(negedge clk) begin
    if (!src_rst_n) begin
      low_cnt = 0;
    end else if (!dst_rst_req_n) begin
      low_cnt = prev_dst ? 1 : low_cnt + 1;
    end
    prev_dst = dst_rst_req_n;
    if (src_rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        check("done_low_len", 32'(low_cnt), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int busy_hi;
    src_rst_n = 1'b0;
    rst_req   = 1'b0;

    // reset state
    tick();
    tick();
    @(negedge clk);
    check("rst_dst", 32'(dst_rst_req_n), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(timeout_err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_ASSERT));
    tick();
    tick();
    tick();

    // power-on sequence: 1 held-reset cycle + 8 ASSERT-counted, 1 WAIT_LO
    exp_q.push_back(16'd9);
    src_rst_n = 1'b1;
    wait_idle(100);
    check("por_dst_high", 32'(dst_rst_req_n), 32'd1);
    check("por_state", 32'(dbg_state), 32'(ST_IDLE));
    check("por_err", 32'(timeout_err), 32'd0);
    repeat (8) tick();

    // latency: request sampled at one edge, reset request low right after
    exp_q.push_back(16'd9);
    pulse_req();
    @(negedge clk);
    check("lat_dst_low", 32'(dst_rst_req_n), 32'd0);
    check("lat_busy", 32'(busy), 32'd1);
    wait_idle(100);
    check("lat_dst_high", 32'(dst_rst_req_n), 32'd1);
    repeat (8) tick();

    // request during WAIT_HI is dropped
    exp_q.push_back(16'd9);
    pulse_req();
    repeat (11) tick();
    pulse_req();
    wait_idle(100);
    busy_hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) busy_hi++;
    end
    check("ign_no_second_seq", 32'(busy_hi), 32'd0);
    check("ign_state", 32'(dbg_state), 32'(ST_IDLE));
    tick();
    repeat (8) tick();

    // reset in RELEASE aborts and restarts without a done
    exp_q.push_back(16'd9);
    pulse_req();
    repeat (9) tick();
    check("mid_in_release", 32'(dbg_state), 32'(ST_RELEASE));
    src_rst_n = 1'b0;
    tick();
    @(negedge clk);
    check("mid_dst_low", 32'(dst_rst_req_n), 32'd0);
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_state", 32'(dbg_state), 32'(ST_ASSERT));
    tick();
    src_rst_n = 1'b1;
    wait_idle(100);
    check("mid_restart_dst", 32'(dst_rst_req_n), 32'd1);
    repeat (8) tick();

`ifdef RST_SEQ_TIMEOUT_EN
    // ack stuck high: WAIT_LO entered 8 edges after request, times out TMO later
    ack_mode = 1;
    pulse_req();
    repeat (TMO + 7) tick();
    @(negedge clk);
    check("tlo_err_before", 32'(timeout_err), 32'd0);
    check("tlo_busy_before", 32'(busy), 32'd1);
    tick();
    @(negedge clk);
    check("tlo_err", 32'(timeout_err), 32'd1);
    check("tlo_busy", 32'(busy), 32'd0);
    check("tlo_dst", 32'(dst_rst_req_n), 32'd1);
    check("tlo_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (10) tick();

    // ack stuck low: times out of WAIT_HI; next request clears the flag
    ack_mode = 2;
    pulse_req();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (timeout_err) break;
    end
    check("thi_err", 32'(timeout_err), 32'd1);
    check("thi_busy", 32'(busy), 32'd0);
    check("thi_dst", 32'(dst_rst_req_n), 32'd1);
    ack_mode = 0;
    repeat (8) tick();
    exp_q.push_back(16'd9);
    pulse_req();
    @(negedge clk);
    check("thi_err_cleared", 32'(timeout_err), 32'd0);
    wait_idle(100);
`else
    check("no_tmo_err", 32'(timeout_err), 32'd0);
`endif

    repeat (5) tick();
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
